// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmitter and its bit counter.
// Pure declarations: no logic, no latency, no backpressure.
// The PARITY state is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int PISO_WIDTH_DEFAULT = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit index counter 0..WIDTH-1 with clear and an is_last flag (shared with the SIPO receiver).
// Latency: cnt updates on the edge after clr/en; is_last is combinational from cnt.
// Backpressure: none; the owner decides when to count via en.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_WIDTH_DEFAULT,
    localparam int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          is_last
);

    assign is_last = (cnt == CW'(WIDTH - 1));

    // Wrapping at the last bit keeps cnt inside 0..WIDTH-1 with no stray values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= is_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, with per-bit valid/first/last; parity bit when PISO_PARITY_EN is defined.
// Latency: word accepted at edge N puts bit 0 on sout in the cycle after edge N; back-to-back words stream with no gap.
// Backpressure: d_ready only in IDLE or on the final frame bit; d_valid without d_ready is ignored.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             par;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             accept;

    assign d_ready = rst && (state == IDLE || sout_last);
    assign accept  = d_valid && d_ready;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state == SHIFT),
        .cnt     (cnt),
        .is_last (cnt_last)
    );

    assign sout_valid = (state == SHIFT) || (state == PARITY);
    assign sout_first = (state == SHIFT) && (cnt == '0);

`ifdef PISO_PARITY_EN
    // par already folds in the final data bit by the time PARITY is entered.
    assign sout_last = (state == PARITY);
    assign sout      = (state == SHIFT) ? sr[0] : ((state == PARITY) ? par : 1'b0);
`else
    assign sout_last = (state == SHIFT) && cnt_last;
    assign sout      = (state == SHIFT) ? sr[0] : 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            par   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= d;
                        par   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr >> 1;
                    par <= par ^ sr[0];
                    if (cnt_last) begin
`ifdef PISO_PARITY_EN
                        state <= PARITY;
`else
                        // Zero-gap streaming: the next word loads on the last bit's edge.
                        if (accept) begin
                            sr  <= d;
                            par <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
`endif
                    end
                end
                PARITY: begin
                    if (accept) begin
                        sr    <= d;
                        par   <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: table of words plus hand-written corner sequences, scoreboard of expected serial bits.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } bit_t;

    typedef struct {
        logic [W-1:0] d;
        logic         par;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic         d_valid;
    logic         d_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_first;
    logic         sout_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_len  = 0;
    int   max_run  = 0;
    bit_t q[$];
    vec_t tbl[7];

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_first (sout_first),
        .sout_last  (sout_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic p);
        bit_t e;
        for (int i = 0; i < W; i++) begin
            e.b = w[i];
            e.f = (i == 0);
            e.l = (i == W - 1) && (PAR == 0);
            q.push_back(e);
        end
        if (PAR != 0) begin
            e.b = p;
            e.f = 1'b0;
            e.l = 1'b1;
            q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] w, input logic p);
        bit done;
        done    = 1'b0;
        d       = w;
        d_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if (d_ready === 1'b1) begin
                @(posedge clk);
                push_word(w, p);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", q.size(), 32'd0);
    endtask

    // Scoreboard consumer: every valid bit must match the next expected bit.
    always @(negedge clk) begin
        bit_t e;
        if (sout_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (q.size() == 0) begin
                chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sout_first_last", {29'd0, sout, sout_first, sout_last}, {29'd0, e.b, e.f, e.l});
            end
        end else begin
            run_len = 0;
            chk("idle_outputs", {28'd0, sout_valid, sout, sout_first, sout_last}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{d: 4'b1011, par: 1'b1};
        tbl[1] = '{d: 4'b0011, par: 1'b0};
        tbl[2] = '{d: 4'b0110, par: 1'b0};
        tbl[3] = '{d: 4'b1111, par: 1'b0};
        tbl[4] = '{d: 4'b0000, par: 1'b0};
        tbl[5] = '{d: 4'b1000, par: 1'b1};
        tbl[6] = '{d: 4'b0010, par: 1'b1};

        // Reset hold with an offered word
        rst     = 1'b0;
        d       = 4'hF;
        d_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_d_ready", d_ready, 32'd0);
            chk("reset_sout_valid", sout_valid, 32'd0);
            chk("reset_sout", sout, 32'd0);
        end
        d_valid = 1'b0;
        rst     = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_no_frame", max_run, 32'd0);
        chk("post_reset_d_ready", d_ready, 32'd1);

        // Table of single words, each followed by return to idle
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].d, tbl[i].par);
            d_valid = 1'b0;
            drain();
            chk("idle_d_ready", d_ready, 32'd1);
        end

        // Back-to-back words with no gap
        max_run = 0;
        send(4'b0001, 1'b1);
        send(4'b1000, 1'b1);
        d_valid = 1'b0;
        drain();
        chk("b2b_contiguous_bits", max_run, 2 * (W + PAR));

        // Mid-frame reset
        send(4'b1111, 1'b0);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_d_ready", d_ready, 32'd0);
        @(posedge clk);
        #1;
        chk("midreset_sout_valid", sout_valid, 32'd0);
        chk("midreset_dropped_bits", q.size(), W - 2 + PAR);
        q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_still_idle", sout_valid, 32'd0);
        send(4'b0010, 1'b1);
        d_valid = 1'b0;
        drain();

        // d toggles with d_valid high mid-frame; only the ready-cycle word is taken
        max_run = 0;
        send(4'b0110, 1'b0);
        for (int t = 0; t < 20 && d_ready !== 1'b1; t++) begin
            d = W'($urandom);
            @(posedge clk);
            #1;
        end
        send(4'b1001, 1'b0);
        d_valid = 1'b0;
        drain();
        chk("ignored_input_contiguous", max_run, 2 * (W + PAR));

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
